// File: rtl/cdc_in_fifo.sv
// Byte-wide first-word-fall-through FIFO feeding one usb_cdc IN channel.
// Single clock domain; occupancy counter keeps full and empty unambiguous.
module cdc_in_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    output logic [WIDTH-1:0]         in_data_o,
    output logic                     in_valid_o,
    input  logic                     in_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     almost_full_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          overflow_q, overflow_d;

    logic wr_en;
    logic rd_en;

    // Handshake flags depend on registered occupancy only, so a read in the
    // full cycle cannot open the write side until the following cycle.
    assign wr_ready_o    = (count_q != FULL_LVL);
    assign in_valid_o    = (count_q != '0);
    assign level_o       = count_q;
    assign almost_full_o = (count_q >= AF_LVL);
    assign overflow_o    = overflow_q;
    assign in_data_o     = mem[rd_ptr_q];

    assign wr_en = wr_valid_i && wr_ready_o && !flush_i;
    assign rd_en = in_valid_o && in_ready_i && !flush_i;

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_valid_i && !wr_ready_o) begin
                overflow_d = 1'b1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; in_valid_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_cdc_in_fifo.sv
// Self-checking bench for cdc_in_fifo: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_cdc_in_fifo;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             wr_valid_i;
    logic             wr_ready_o;
    logic [WIDTH-1:0] in_data_o;
    logic             in_valid_o;
    logic             in_ready_i;
    logic             flush_i;
    logic [LW-1:0]    level_o;
    logic             almost_full_o;
    logic             overflow_o;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] mq [$];
    logic             movf = 1'b0;

    cdc_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_data_i     (wr_data_i),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .in_data_o     (in_data_o),
        .in_valid_o    (in_valid_o),
        .in_ready_i    (in_ready_i),
        .flush_i       (flush_i),
        .level_o       (level_o),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock: advance the reference model on the edge, then compare 1ns later.
    task automatic tick();
        logic wr, rd, full;
        @(posedge clk_i);
        full = (mq.size() == DEPTH);
        wr   = wr_valid_i && !full;
        rd   = in_ready_i && (mq.size() != 0);
        if (rst_i || flush_i) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            if (wr_valid_i && full) movf = 1'b1;
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back(wr_data_i);
        end
        #1;
        checks++;
        if (level_o !== LW'(mq.size())) begin
            errors++;
            $display("FAIL model_level: got %0d expected %0d", level_o, mq.size());
        end
        checks++;
        if (in_valid_o !== (mq.size() != 0)) begin
            errors++;
            $display("FAIL model_in_valid: got %b expected %b", in_valid_o, mq.size() != 0);
        end
        checks++;
        if (wr_ready_o !== (mq.size() != DEPTH)) begin
            errors++;
            $display("FAIL model_wr_ready: got %b expected %b", wr_ready_o, mq.size() != DEPTH);
        end
        checks++;
        if (almost_full_o !== (mq.size() >= AF_LEVEL)) begin
            errors++;
            $display("FAIL model_almost_full: got %b expected %b", almost_full_o, mq.size() >= AF_LEVEL);
        end
        checks++;
        if (overflow_o !== movf) begin
            errors++;
            $display("FAIL model_overflow: got %b expected %b", overflow_o, movf);
        end
        if (mq.size() != 0) begin
            checks++;
            if (in_data_o !== mq[0]) begin
                errors++;
                $display("FAIL model_head: got %02h expected %02h", in_data_o, mq[0]);
            end
        end
    endtask

    task automatic idle_inputs();
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
        in_ready_i = 1'b0;
        flush_i    = 1'b0;
        rst_i      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        checks++;
        if ({level_o, in_valid_o, wr_ready_o, almost_full_o, overflow_o} !== {LW'(0), 4'b0100}) begin
            errors++;
            $display("FAIL reset_state: got lvl=%0d v=%b r=%b af=%b ov=%b required 0 0 1 0 0",
                     level_o, in_valid_o, wr_ready_o, almost_full_o, overflow_o);
        end
    endtask

    task automatic test_first_word();
        logic [7:0] bytes [3];
        bytes = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 3; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = bytes[i];
            tick();
            if (i == 0) begin
                checks++;
                if (in_valid_o !== 1'b1 || in_data_o !== 8'h41) begin
                    errors++;
                    $display("FAIL first_word_latency: got v=%b d=%02h required v=1 d=41", in_valid_o, in_data_o);
                end
            end
        end
        wr_valid_i = 1'b0;
        tick();
        checks++;
        if (level_o !== LW'(3) || in_data_o !== 8'h41) begin
            errors++;
            $display("FAIL first_word_hold: got lvl=%0d d=%02h required 3 41", level_o, in_data_o);
        end
        in_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_ready_i = 1'b0;
    endtask

    task automatic test_fill_overflow();
        in_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'(i);
            tick();
            checks++;
            if (almost_full_o !== (i + 1 >= 12)) begin
                errors++;
                $display("FAIL fill_almost_full at level %0d: got %b required %b", i + 1, almost_full_o, i + 1 >= 12);
            end
        end
        checks++;
        if (wr_ready_o !== 1'b0 || level_o !== LW'(16)) begin
            errors++;
            $display("FAIL fill_full: got r=%b lvl=%0d required r=0 lvl=16", wr_ready_o, level_o);
        end
        wr_data_i = 8'hFF;
        tick();
        checks++;
        if (overflow_o !== 1'b1 || level_o !== LW'(16)) begin
            errors++;
            $display("FAIL overflow_set: got ov=%b lvl=%0d required ov=1 lvl=16", overflow_o, level_o);
        end
    endtask

    task automatic test_full_read_write();
        checks++;
        if (in_data_o !== 8'h00) begin
            errors++;
            $display("FAIL full_head: got %02h required 00", in_data_o);
        end
        wr_valid_i = 1'b1;
        wr_data_i  = 8'hAA;
        in_ready_i = 1'b1;
        tick();
        checks++;
        if (level_o !== LW'(15) || wr_ready_o !== 1'b1 || in_data_o !== 8'h01) begin
            errors++;
            $display("FAIL full_rw: got lvl=%0d r=%b d=%02h required 15 1 01", level_o, wr_ready_o, in_data_o);
        end
        wr_valid_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (in_data_o !== 8'(i)) begin
                errors++;
                $display("FAIL drain_order: got %02h required %02h", in_data_o, 8'(i));
            end
            tick();
        end
        in_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        checks++;
        if (level_o !== LW'(5) || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_precondition: got lvl=%0d ov=%b required 5 1", level_o, overflow_o);
        end
        flush_i    = 1'b1;
        wr_valid_i = 1'b1;
        wr_data_i  = 8'h55;
        tick();
        flush_i = 1'b0;
        checks++;
        if (level_o !== LW'(0) || in_valid_o !== 1'b0 || overflow_o !== 1'b0 || wr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got lvl=%0d v=%b ov=%b r=%b required 0 0 0 1",
                     level_o, in_valid_o, overflow_o, wr_ready_o);
        end
        wr_data_i = 8'h11;
        tick();
        wr_valid_i = 1'b0;
        checks++;
        if (in_data_o !== 8'h11 || level_o !== LW'(1)) begin
            errors++;
            $display("FAIL flush_discard: got d=%02h lvl=%0d required 11 1", in_data_o, level_o);
        end
        in_ready_i = 1'b1;
        tick();
        in_ready_i = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] outq [$];
        int sent = 0;
        int max_lvl = 0;
        int cyc = 0;
        while ((sent < 100 || level_o != 0) && cyc < 2000) begin
            wr_valid_i = (sent < 100);
            wr_data_i  = 8'(sent);
            in_ready_i = (sent >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
            if (in_valid_o && in_ready_i) outq.push_back(in_data_o);
            if (wr_valid_i && wr_ready_o) sent++;
            tick();
            if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
            cyc++;
        end
        idle_inputs();
        checks++;
        if (cyc >= 2000 || sent != 100) begin
            errors++;
            $display("FAIL stream_timeout: sent %0d of 100 in %0d cycles", sent, cyc);
        end
        checks++;
        if (max_lvl > DEPTH) begin
            errors++;
            $display("FAIL stream_max_level: got %0d limit %0d", max_lvl, DEPTH);
        end
        checks++;
        if (outq.size() != 100) begin
            errors++;
            $display("FAIL stream_count: got %0d required 100", outq.size());
        end
        for (int i = 0; i < outq.size() && i < 100; i++) begin
            checks++;
            if (outq[i] !== 8'(i)) begin
                errors++;
                $display("FAIL stream_data[%0d]: got %02h required %02h", i, outq[i], 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        in_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'(8'h30 + i);
            tick();
        end
        checks++;
        if (level_o !== LW'(9)) begin
            errors++;
            $display("FAIL reset_mid_precondition: got lvl=%0d required 9", level_o);
        end
        rst_i      = 1'b1;
        in_ready_i = 1'b1;
        wr_data_i  = 8'h99;
        tick();
        rst_i      = 1'b0;
        in_ready_i = 1'b0;
        checks++;
        if ({level_o, in_valid_o, wr_ready_o, almost_full_o, overflow_o} !== {LW'(0), 4'b0100}) begin
            errors++;
            $display("FAIL reset_mid_state: got lvl=%0d v=%b r=%b af=%b ov=%b required 0 0 1 0 0",
                     level_o, in_valid_o, wr_ready_o, almost_full_o, overflow_o);
        end
        wr_data_i = 8'h7E;
        tick();
        wr_valid_i = 1'b0;
        checks++;
        if (in_data_o !== 8'h7E || in_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_first: got v=%b d=%02h required 1 7E", in_valid_o, in_data_o);
        end
        in_ready_i = 1'b1;
        tick();
        in_ready_i = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            wr_valid_i = 1'($urandom_range(0, 99) < 60);
            wr_data_i  = 8'($urandom);
            in_ready_i = 1'($urandom_range(0, 99) < 45);
            flush_i    = 1'($urandom_range(0, 63) == 0);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_first_word();
        test_fill_overflow();
        test_full_read_write();
        test_flush();
        test_stream();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdc_in_fifo.md
Name: cdc_in_fifo

Overview:
- Byte-wide first-word-fall-through (FWFT) FIFO on the application side of one usb_cdc IN channel.
- Buffers bytes from application logic and presents them to the usb_cdc in_data/in_valid/in_ready handshake.
- Decouples bursty producers from host polling of the IN bulk endpoint.
- One instance per channel; runs entirely in the usb_cdc application clock domain.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 16: number of entries. Power of two, minimum 2.
- AF_LEVEL, 12: almost_full_o asserts when level_o >= AF_LEVEL. Range 1..DEPTH.

Ports:
- clk_i  input  1  application clock; all logic rising-edge.
- rst_i  input  1  synchronous reset, active-high.
- wr_data_i  input  WIDTH  byte from the application.
- wr_valid_i  input  1  application offers wr_data_i.
- wr_ready_o  output  1  FIFO can accept a byte this cycle.
- in_data_o  output  WIDTH  byte to usb_cdc in_data_i.
- in_valid_o  output  1  byte available, to usb_cdc in_valid_i.
- in_ready_i  input  1  usb_cdc in_ready_o; consumes the head byte when high with in_valid_o.
- flush_i  input  1  discard all contents.
- level_o  output  log2(DEPTH)+1  current occupancy.
- almost_full_o  output  1  level_o >= AF_LEVEL.
- overflow_o  output  1  sticky: a write was attempted while full.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i; it is sampled at the clk_i edge.
- Reset state: pointers = 0, level_o = 0, in_valid_o = 0, wr_ready_o = 1, almost_full_o = 0, overflow_o = 0.
- in_data_o is don't-care while in_valid_o = 0. Storage array is not reset.
- Write occurs when wr_valid_i && wr_ready_o. Byte is stored at wr_ptr; wr_ptr wraps modulo DEPTH.
- Read occurs when in_valid_o && in_ready_i. Head is released; rd_ptr wraps modulo DEPTH.
- wr_ready_o = (level_o != DEPTH). It is a registered-state function only, with no combinational path from in_ready_i.
  - When full, a simultaneous read does not enable a write that cycle. wr_ready_o rises the next cycle.
- in_valid_o = (level_o != 0). in_data_o = mem[rd_ptr], combinational from storage and registered pointer.
- Latency: a byte written into an empty FIFO appears on in_data_o with in_valid_o = 1 on the following cycle.
- in_data_o and in_valid_o are stable while in_valid_o = 1 and in_ready_i = 0, as the usb_cdc handshake requires.
- level_o updates each cycle:
  - +1 on write only.
  - -1 on read only.
  - unchanged on simultaneous write+read (possible only when 0 < level_o < DEPTH).
- Use a pointer-plus-wrap-bit or a separate counter so that full and empty are unambiguous at DEPTH entries.
- almost_full_o is derived from level_o and has the same timing.
- overflow_o sets on the cycle after any cycle with wr_valid_i = 1 and wr_ready_o = 0. The offered byte is dropped, not stored. overflow_o is cleared only by rst_i or flush_i.
- flush_i has priority over everything:
  - On the next cycle, pointers = 0, level_o = 0, overflow_o = 0.
  - A write or read in the same cycle as flush_i has no effect; the write byte is discarded.
  - wr_ready_o is not forced low by flush_i.
- rst_i mid-transfer: same result as flush_i. No partial state survives.
- Wrap-around: after DEPTH writes and DEPTH reads the pointers return to 0 with no data corruption, including back-to-back full/empty transitions.
- Throughput: sustains one byte per cycle in and out simultaneously when 0 < level_o < DEPTH.

Test Plan:
- Reset, then write 0x41,0x42,0x43 with in_ready_i = 0 -> in_valid_o = 1 one cycle after the first write; in_data_o holds 0x41; level_o = 3.
- Fill 16 bytes (0x00..0x0F) with in_ready_i = 0 -> wr_ready_o = 0 when level_o = 16; almost_full_o = 1 from level_o = 12. Then one more write of 0xFF -> overflow_o = 1 next cycle; level_o stays 16; drain returns 0x00..0x0F in order.
- Full FIFO, in_ready_i = 1 and wr_valid_i = 1 in the same cycle -> exactly one read, no write; level_o = 15; wr_ready_o = 1 next cycle.
- Continuous streaming of 100 incrementing bytes with in_ready_i toggling in a pseudo-random pattern -> output sequence identical and gap-free in value; level_o never exceeds 16; pointers wrap at least 6 times.
- Level 5 with overflow_o = 1; assert flush_i together with a write of 0x55 -> next cycle level_o = 0, in_valid_o = 0, overflow_o = 0; 0x55 is never output.
- Assert rst_i during a streaming burst with level_o = 9 -> next cycle all outputs match the reset values; the next write after reset of 0x7E is output first.
